// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler that shares one start/done binary-to-BCD converter among
// NREQ requesters, returns tagged results over valid/ready, and aborts hung conversions.
module bcd_conv_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*12-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               conv_start,
    output logic [11:0]        conv_bin,
    input  logic               conv_done,
    input  logic [3:0]         conv_d3,
    input  logic [3:0]         conv_d2,
    input  logic [3:0]         conv_d1,
    input  logic [3:0]         conv_d0,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [15:0]        rsp_bcd,
    output logic               err
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    // Timer only has to hold values up to TIMEOUT-1.
    localparam int TW = $clog2(TIMEOUT);

    state_t          state;
    logic [IDW-1:0]  rr;
    logic [IDW-1:0]  id;
    logic [IDW-1:0]  id_next;
    logic [TW-1:0]   timer;
    logic [IDW-1:0]  win;
    logic            found;
    logic [NREQ-1:0] grant;
    logic [11:0]     sel_data;
    int              idx;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no latch is inferred.
        found    = 1'b0;
        win      = '0;
        grant    = '0;
        sel_data = '0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (idx == j) && req_valid[j]) begin
                    found = 1'b1;
                    win   = IDW'(j);
                end
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            grant[j] = found && (win == IDW'(j));
            if (win == IDW'(j)) sel_data = req_data[12*j +: 12];
        end
    end

    // Pointer and ID wrap at NREQ, not at 2**IDW.
    assign id_next   = (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
    assign req_ready = ((state == IDLE) && n_rst) ? grant : '0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            rr         <= '0;
            id         <= '0;
            timer      <= '0;
            conv_start <= 1'b0;
            conv_bin   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_bcd    <= '0;
            err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only, so every branch reads pre-edge values.
            conv_start <= 1'b0;
            err        <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        conv_bin   <= sel_data;
                        id         <= win;
                        conv_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    // A done arriving in the timeout cycle still wins over the abort.
                    if (conv_done) begin
                        rsp_bcd   <= {conv_d3, conv_d2, conv_d1, conv_d0};
                        rsp_id    <= id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (timer == TW'(TIMEOUT - 2)) begin
                        err   <= 1'b1;
                        rr    <= id_next;
                        state <= IDLE;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr        <= id_next;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed bench for bcd_conv_scheduler: a vector table of single conversions plus
// hand-written arbitration, backpressure, timeout, spurious-done and reset sequences.
module tb_bcd_conv_scheduler;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 32;

    logic               clk = 1'b0;
    logic               n_rst = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*12-1:0] req_data = '0;
    logic [NREQ-1:0]    req_ready;
    logic               conv_start;
    logic [11:0]        conv_bin;
    logic               conv_done = 1'b0;
    logic [3:0]         conv_d3 = '0;
    logic [3:0]         conv_d2 = '0;
    logic [3:0]         conv_d1 = '0;
    logic [3:0]         conv_d0 = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [IDW-1:0]     rsp_id;
    logic [15:0]        rsp_bcd;
    logic               err;

    bcd_conv_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .conv_start(conv_start), .conv_bin(conv_bin), .conv_done(conv_done),
        .conv_d3(conv_d3), .conv_d2(conv_d2), .conv_d1(conv_d1), .conv_d0(conv_d0),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_bcd(rsp_bcd), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          req;
        logic [11:0] data;
        int          lat;
        logic [1:0]  exp_id;
        logic [15:0] exp_bcd;
    } vec_t;

    int              n_vec = 0;
    int              n_bad = 0;
    int              cyc = 0;
    bit              acc = 0;
    int              acc_cyc = 0;
    logic [NREQ-1:0] acc_mask = '0;
    bit              chk_onehot = 0;
    int              model_l = -1;
    int              mcnt = 0;
    logic [11:0]     mop = '0;
    int              err_cnt = 0;
    int              rsp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input logic [11:0] v);
        int x;
        x = int'(v);
        return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    // One clock cycle: sample accepts before the edge, then run the converter model after it.
    task automatic tick();
        #1;
        if ((req_valid & req_ready) != '0) begin
            acc      = 1;
            acc_cyc  = cyc;
            acc_mask = req_valid & req_ready;
        end
        if (chk_onehot) check("req_ready_onehot", 32'($countones(req_ready) <= 1), 1);
        @(posedge clk);
        #1;
        cyc++;
        conv_done = 1'b0;
        {conv_d3, conv_d2, conv_d1, conv_d0} = '0;
        if (!n_rst) begin
            mcnt = 0;
        end else if (conv_start) begin
            mop  = conv_bin;
            mcnt = model_l;
        end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                conv_done = 1'b1;
                {conv_d3, conv_d2, conv_d1, conv_d0} = to_bcd(mop);
            end
        end
        if (err) err_cnt++;
        if (rsp_valid) rsp_cnt++;
    endtask

    task automatic wait_acc(output bit ok);
        int n;
        n   = 0;
        acc = 0;
        while (!acc && n < 60) begin
            tick();
            n++;
        end
        check("accept_wait", 32'(acc), 1);
        ok = acc;
    endtask

    task automatic wait_rsp(output bit ok);
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check("rsp_wait", 32'(rsp_valid), 1);
        ok = rsp_valid;
    endtask

    task automatic run_one(input int r, input logic [11:0] d, input int lat,
                           input logic [1:0] eid, input logic [15:0] ebcd);
        bit ok;
        int t0;
        model_l = lat;
        req_data[12*r +: 12] = d;
        req_valid = '0;
        req_valid[r] = 1'b1;
        wait_acc(ok);
        req_valid = '0;
        if (!ok) return;
        t0 = acc_cyc;
        check("grant_mask", 32'(acc_mask), 32'(1 << r));
        check("start_pulse", 32'(conv_start), 1);
        check("conv_bin", 32'(conv_bin), 32'(d));
        check("busy_req_ready", 32'(req_ready), 0);
        wait_rsp(ok);
        if (!ok) return;
        check("rsp_latency", 32'(cyc - t0), 32'(lat + 2));
        check("rsp_id", 32'(rsp_id), 32'(eid));
        check("rsp_bcd", 32'(rsp_bcd), 32'(ebcd));
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t        vecs[6];
        int          order[5];
        logic [15:0] rr_bcd[4];
        bit          ok;
        int          s;
        int          h;
        int          n;
        int          e0;
        int          r0;

        vecs[0] = '{req: 2, data: 12'd4095, lat: 14, exp_id: 2'd2, exp_bcd: 16'h4095};
        vecs[1] = '{req: 1, data: 12'd9,    lat: 1,  exp_id: 2'd1, exp_bcd: 16'h0009};
        vecs[2] = '{req: 3, data: 12'd10,   lat: 3,  exp_id: 2'd3, exp_bcd: 16'h0010};
        vecs[3] = '{req: 0, data: 12'd1234, lat: 5,  exp_id: 2'd0, exp_bcd: 16'h1234};
        vecs[4] = '{req: 1, data: 12'd700,  lat: 20, exp_id: 2'd1, exp_bcd: 16'h0700};
        vecs[5] = '{req: 3, data: 12'd2048, lat: 30, exp_id: 2'd3, exp_bcd: 16'h2048};

        // Reset state, with requests pending to show req_ready is held low.
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_conv_start", 32'(conv_start), 0);
        check("reset_conv_bin", 32'(conv_bin), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_id", 32'(rsp_id), 0);
        check("reset_rsp_bcd", 32'(rsp_bcd), 0);
        check("reset_err", 32'(err), 0);
        req_valid = '0;
        n_rst = 1'b1;
        tick();

        // Round robin with all requesters busy, starting from pointer 0.
        order  = '{0, 1, 2, 3, 0};
        rr_bcd = '{16'h0000, 16'h0009, 16'h0010, 16'h1234};
        req_data = {12'd1234, 12'd10, 12'd9, 12'd0};
        model_l = 14;
        chk_onehot = 1;
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            wait_acc(ok);
            if (i == 4) req_valid = '0;
            if (!ok) break;
            check("rr_grant", 32'(acc_mask), 32'(1 << order[i]));
            wait_rsp(ok);
            if (!ok) break;
            check("rr_id", 32'(rsp_id), 32'(order[i]));
            check("rr_bcd", 32'(rsp_bcd), 32'(rr_bcd[order[i]]));
            tick();
        end
        req_valid = '0;
        chk_onehot = 0;

        for (int i = 0; i < 6; i++)
            run_one(vecs[i].req, vecs[i].data, vecs[i].lat, vecs[i].exp_id, vecs[i].exp_bcd);

        // Backpressure: response held for 10 cycles while requester 2 waits.
        rsp_ready = 1'b0;
        model_l = 4;
        req_data[12 +: 12] = 12'd567;
        req_data[24 +: 12] = 12'd42;
        req_valid = 4'b0010;
        wait_acc(ok);
        req_valid = 4'b0100;
        wait_rsp(ok);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_id", 32'(rsp_id), 1);
            check("bp_bcd", 32'(rsp_bcd), 32'h0567);
            check("bp_req_ready", 32'(req_ready), 0);
            tick();
        end
        h = cyc;
        rsp_ready = 1'b1;
        tick();
        check("bp_valid_drop", 32'(rsp_valid), 0);
        check("bp_next_ready", 32'(req_ready), 32'b0100);
        wait_acc(ok);
        req_valid = '0;
        check("bp_accept_cycle", 32'(acc_cyc), 32'(h + 1));
        wait_rsp(ok);
        check("bp_next_bcd", 32'(rsp_bcd), 32'h0042);
        check("bp_next_id", 32'(rsp_id), 2);
        tick();

        // Watchdog: converter never answers.
        model_l = -1;
        req_data[0 +: 12] = 12'd100;
        req_valid = 4'b0001;
        wait_acc(ok);
        req_valid = '0;
        s  = cyc;
        e0 = err_cnt;
        r0 = rsp_cnt;
        check("to_start", 32'(conv_start), 1);
        n = 0;
        while (!err && n < 60) begin
            tick();
            n++;
        end
        check("to_err_seen", 32'(err), 1);
        check("to_err_cycle", 32'(cyc - s), 32);
        tick();
        check("to_err_pulse", 32'(err), 0);
        check("to_err_count", 32'(err_cnt - e0), 1);
        check("to_no_rsp", 32'(rsp_cnt - r0), 0);
        model_l = 3;
        req_valid = '1;
        wait_acc(ok);
        req_valid = '0;
        check("to_next_grant", 32'(acc_mask), 32'b0010);
        wait_rsp(ok);
        check("to_next_bcd", 32'(rsp_bcd), 32'h0567);
        tick();

        // Spurious done in IDLE must not move the FSM or touch the response.
        conv_done = 1'b1;
        {conv_d3, conv_d2, conv_d1, conv_d0} = 16'h9876;
        tick();
        check("spur_idle_valid", 32'(rsp_valid), 0);
        check("spur_idle_start", 32'(conv_start), 0);
        check("spur_idle_bcd", 32'(rsp_bcd), 32'h0567);
        check("spur_idle_err", 32'(err), 0);

        // Spurious done in RESP must not overwrite the held result.
        rsp_ready = 1'b0;
        model_l = 6;
        req_data[24 +: 12] = 12'd321;
        req_valid = 4'b0100;
        wait_acc(ok);
        req_valid = '0;
        wait_rsp(ok);
        conv_done = 1'b1;
        {conv_d3, conv_d2, conv_d1, conv_d0} = 16'h5555;
        tick();
        check("spur_resp_valid", 32'(rsp_valid), 1);
        check("spur_resp_id", 32'(rsp_id), 2);
        check("spur_resp_bcd", 32'(rsp_bcd), 32'h0321);
        rsp_ready = 1'b1;
        tick();

        // Done in the very cycle the watchdog would fire.
        e0 = err_cnt;
        run_one(3, 12'd999, TIMEOUT - 1, 2'd3, 16'h0999);
        check("coincide_no_err", 32'(err_cnt - e0), 0);

        // Reset in the middle of WAIT, with a non-zero round-robin pointer.
        run_one(0, 12'd5, 2, 2'd0, 16'h0005);
        model_l = 20;
        req_data[24 +: 12] = 12'd4095;
        req_valid = 4'b0100;
        wait_acc(ok);
        req_valid = '1;
        repeat (3) tick();
        n_rst = 1'b0;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 0);
        check("mid_rst_conv_start", 32'(conv_start), 0);
        check("mid_rst_conv_bin", 32'(conv_bin), 0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        check("mid_rst_rsp_id", 32'(rsp_id), 0);
        check("mid_rst_rsp_bcd", 32'(rsp_bcd), 0);
        check("mid_rst_err", 32'(err), 0);
        tick();
        tick();
        req_valid = '0;
        n_rst = 1'b1;
        e0 = err_cnt;
        r0 = rsp_cnt;
        repeat (40) tick();
        check("post_rst_no_err", 32'(err_cnt - e0), 0);
        check("post_rst_no_rsp", 32'(rsp_cnt - r0), 0);
        model_l = 2;
        req_valid = '1;
        wait_acc(ok);
        req_valid = '0;
        check("post_rst_rr_zero", 32'(acc_mask), 32'b0001);
        wait_rsp(ok);
        check("post_rst_bcd", 32'(rsp_bcd), 32'h0005);
        check("post_rst_id", 32'(rsp_id), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bcd_conv_scheduler.md
Name: bcd_conv_scheduler

Overview:
- Shares one handshake-style 12-bit binary-to-BCD converter among NREQ independent requesters.
- Uses round-robin arbitration between requesters.
- Sequences each conversion with a start/done handshake to the converter.
- Returns the 4-digit BCD result tagged with the requester ID through a valid/ready response port with backpressure.
- A watchdog aborts conversions that never complete.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID (must satisfy 2**IDW >= NREQ).
- TIMEOUT, 32, max cycles in WAIT before abort (>= 16).

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  NREQ*12  packed binary operands; requester i uses bits [12*i+11:12*i].
- req_ready  out  NREQ  one-hot grant/accept; a request transfers when req_valid[i] & req_ready[i].
- conv_start  out  1  one-cycle start pulse to the converter.
- conv_bin  out  12  operand to the converter; held stable from START through WAIT.
- conv_done  in  1  one-cycle completion pulse from the converter.
- conv_d3, conv_d2, conv_d1, conv_d0  in  4 each  converter BCD digits (d3 = thousands); valid in the conv_done cycle.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester ID of the response.
- rsp_bcd  out  16  {d3,d2,d1,d0}.
- err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async, n_rst=0):
  - State IDLE; rr pointer = 0.
  - All outputs 0: req_ready, conv_start, conv_bin, rsp_valid, rsp_id, rsp_bcd, err.
  - Internal operand/ID/timer registers cleared.
  - Reset mid-operation aborts silently: no response, no err.
- State machine IDLE -> START -> WAIT -> RESP -> IDLE. WAIT may also exit to IDLE on timeout.
- IDLE:
  - req_ready is a combinational one-hot of the winner: the first asserted req_valid at or after the rr pointer, wrapping modulo NREQ.
  - With no valid requests, req_ready = 0 and the FSM stays in IDLE.
  - On transfer: latch the operand into conv_bin and the winner index into the ID register; go to START.
- START: conv_start = 1 for exactly one cycle; clear timer; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - On conv_done = 1: register {conv_d3..d0} into rsp_bcd, set rsp_valid = 1 and rsp_id = latched ID; go to RESP.
  - If the timer reaches TIMEOUT-1 without conv_done: err = 1 for one cycle, no response, rr pointer = ID+1 mod NREQ, go to IDLE.
  - conv_done in the same cycle as the timeout wins; no err is raised.
- RESP:
  - rsp_valid, rsp_id and rsp_bcd stay stable until rsp_ready = 1.
  - In the handshake cycle: rsp_valid goes to 0 on the next edge, rr pointer = ID+1 mod NREQ, go to IDLE.
  - rsp_ready asserted outside RESP is ignored.
- conv_done outside WAIT is ignored and does not change state or outputs.
- Only one conversion is outstanding at a time. req_ready is 0 in all states other than IDLE.
- Latency:
  - Request accepted at cycle T; conv_start at T+1.
  - conv_done at T+1+L gives rsp_valid at T+2+L.
  - Earliest next accept is the cycle after the response handshake.
- Fairness: a continuously asserted requester is served within NREQ grants.
- Width rules: the rr pointer and ID are IDW bits, wrapping at NREQ (not 2**IDW). rsp_bcd is passed through unchanged with no digit checking.

Test Plan:
- Single request, requester 2, data 12'd4095, converter model L=14, rsp_ready=1 -> conv_start at T+1, conv_bin=0xFFF, rsp_valid at T+16, rsp_id=2, rsp_bcd=16'h4095.
- All 4 req_valid held high, data 0, 9, 10, 1234, model L=14 -> grants in order 0,1,2,3,0; rsp_bcd 0x0000, 0x0009, 0x0010, 0x1234; req_ready is always one-hot or zero.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid/rsp_id/rsp_bcd stable, no req_ready asserted; one cycle after rsp_ready=1, the next request is accepted.
- Timeout: model never asserts conv_done, TIMEOUT=32 -> err high exactly one cycle, 32 cycles after conv_start; no rsp_valid; next grant goes to the next requester.
- Reset mid-WAIT: n_rst low for 2 cycles -> all outputs 0 immediately; no response or err afterwards; rr pointer restarts at 0.
- Spurious conv_done in IDLE and RESP, plus conv_done coinciding with the timeout cycle -> first two are ignored; the third yields a normal response with err=0.
